// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: DMA engine state encoding and fixed register addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ppu_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_GET,
        DMA_PUT
    } dma_state_t;

    // CPU address whose write starts a sprite DMA (data = source page)
    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    // PPU OAMDATA port written on every put cycle
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// Bundle of the CPU snoop inputs and DMA bus outputs of the OAM DMA engine.
// Latency: n/a (wiring only).
// Backpressure: rdy=0 halts the CPU core; there is no other flow control.
//   master : the DMA engine (drives rdy/dma_active/bus_*, snoops cpu_*)
//   slave  : CPU core + bus mux side (drives cpu_*, bus_din)
interface oam_dma_if;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  bus_din;
    logic        rdy;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_dout;

    modport master (
        input  cpu_ce, cpu_addr, cpu_wr, cpu_dout, bus_din,
        output rdy, dma_active, bus_addr, bus_rw, bus_dout
    );

    modport slave (
        output cpu_ce, cpu_addr, cpu_wr, cpu_dout, bus_din,
        input  rdy, dma_active, bus_addr, bus_rw, bus_dout
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: snoops a CPU write to DMA_REG, halts the CPU and copies 256 bytes of page into OAMDATA.
// Latency: HALT one CPU cycle after the trigger, then 512 get/put cycles (+1 ALIGN on odd parity).
// Backpressure: everything advances only on cpu_ce; with cpu_ce low all state and outputs hold.
// Ports: clk, rst (sync, active-high); dma (oam_dma_if.master): cpu_ce/cpu_addr/cpu_wr/cpu_dout
//   snoop, bus_din read data in; rdy, dma_active, bus_addr, bus_rw, bus_dout out.
module oam_dma
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG = ADDR_OAMDMA,
    parameter logic [15:0] OAMDATA = ADDR_OAMDATA
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.master dma
);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  data_q,  data_d;
    logic        put_q,   put_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            data_q  <= 8'h00;
            put_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            data_q  <= data_d;
            put_q   <= put_d;
        end
    end

    // Next-state: nothing moves between CPU cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        data_d  = data_q;
        put_d   = put_q;
        if (dma.cpu_ce) begin
            // Free-running get/put parity, independent of whether a DMA is running
            put_d = ~put_q;
            unique case (state_q)
                DMA_IDLE: begin
                    if (dma.cpu_wr && dma.cpu_addr == DMA_REG) begin
                        page_d  = dma.cpu_dout;
                        state_d = DMA_HALT;
                    end
                end
                // HALT sitting on a put cycle means the next cycle is already a get;
                // otherwise burn one dummy read to line up with the parity.
                DMA_HALT:  state_d = put_q ? DMA_GET : DMA_ALIGN;
                DMA_ALIGN: state_d = DMA_GET;
                DMA_GET: begin
                    data_d  = dma.bus_din;
                    state_d = DMA_PUT;
                end
                DMA_PUT: begin
                    idx_d   = idx_q + 8'd1;   // wraps to 0 after the last byte
                    state_d = (idx_q == 8'hFF) ? DMA_IDLE : DMA_GET;
                end
                default: state_d = DMA_IDLE;
            endcase
        end
    end

    // Outputs depend on registered state only, so no input-to-output path exists.
    always_comb begin
        dma.rdy        = 1'b0;
        dma.dma_active = 1'b1;
        dma.bus_addr   = DMA_REG;
        dma.bus_rw     = 1'b1;
        dma.bus_dout   = 8'h00;
        unique case (state_q)
            DMA_IDLE: begin
                dma.rdy        = 1'b1;
                dma.dma_active = 1'b0;
                dma.bus_addr   = 16'h0000;
            end
            DMA_HALT, DMA_ALIGN: dma.bus_addr = DMA_REG;
            DMA_GET:  dma.bus_addr = {page_q, idx_q};   // no carry into the page byte
            DMA_PUT: begin
                dma.bus_addr = OAMDATA;
                dma.bus_rw   = 1'b0;
                dma.bus_dout = data_q;
            end
            default: begin
                dma.rdy        = 1'b1;
                dma.dma_active = 1'b0;
                dma.bus_addr   = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table for the trigger decode, plus whole transfers
// checked every clock against a transaction-level model (halted-cycle position -> expected bus op).
// Stimulus: randomized cpu_ce gaps, pages, memory contents and trigger parity.
module tb_oam_dma;
    import ppu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_if dif ();
    oam_dma dut (.clk(clk), .rst(rst), .dma(dif));

    logic [7:0] mem [65536];
    assign dif.bus_din = mem[dif.bus_addr];

    int checks   = 0;
    int failures = 0;

    // Reference model: a DMA is a run of 513 (+1 with alignment) halted CPU cycles;
    // position 0 is HALT, optional ALIGN, then read/write pairs per byte.
    bit         m_busy   = 0;
    int         m_pos    = 0;
    bit         m_align  = 0;
    logic [7:0] m_page   = 0;
    int         m_ce_cnt = 0;

    int halted_obs, puts_obs;

    function automatic void model_step(bit r, bit ce, bit wr, logic [15:0] a, logic [7:0] d);
        if (r) begin
            m_busy   = 0;
            m_ce_cnt = 0;
        end else if (ce) begin
            m_ce_cnt++;
            if (!m_busy) begin
                if (wr && a == 16'h4014) begin
                    m_busy  = 1;
                    m_pos   = 0;
                    m_page  = d;
                    // parity flag starts 0 and flips on each CPU cycle; HALT landing on a
                    // get cycle (even count) costs one extra dummy read
                    m_align = (m_ce_cnt % 2 == 0);
                end
            end else begin
                m_pos++;
                if (m_pos == 513 + int'(m_align)) m_busy = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [15:0] ea;
        logic [7:0]  ed;
        bit er, eact, erw, chk_d;
        int k;
        ed = 8'h00; chk_d = 0;
        if (!m_busy) begin
            er = 1; eact = 0; ea = 16'h0000; erw = 1;
        end else begin
            er = 0; eact = 1;
            if (m_pos == 0 || (m_align && m_pos == 1)) begin
                ea = 16'h4014; erw = 1;
            end else begin
                k = m_pos - 1 - int'(m_align);
                if (k % 2 == 0) begin
                    ea = {m_page, 8'(k / 2)}; erw = 1;
                end else begin
                    ea = 16'h2004; erw = 0;
                    ed = mem[{m_page, 8'(k / 2)}]; chk_d = 1;
                end
            end
        end
        checks++;
        if ({dif.rdy, dif.dma_active, dif.bus_addr, dif.bus_rw} !== {er, eact, ea, erw} ||
            (chk_d && dif.bus_dout !== ed)) begin
            failures++;
            $display("FAIL %s t=%0t pos=%0d: got rdy=%b act=%b addr=%h rw=%b dout=%h, want rdy=%b act=%b addr=%h rw=%b dout=%h",
                     tag, $time, m_pos, dif.rdy, dif.dma_active, dif.bus_addr, dif.bus_rw,
                     dif.bus_dout, er, eact, ea, erw, ed);
        end
    endtask

    task automatic do_cycle(input bit r, input bit ce, input bit wr,
                            input logic [15:0] a, input logic [7:0] d, input string tag);
        rst          = r;
        dif.cpu_ce   = ce;
        dif.cpu_wr   = wr;
        dif.cpu_addr = a;
        dif.cpu_dout = d;
        @(posedge clk);
        model_step(r, ce, wr, a, d);
        #1;
        if (!r && ce && !dif.rdy) halted_obs++;
        if (!r && ce && dif.dma_active && !dif.bus_rw) puts_obs++;
        check_outputs(tag);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // want_align: 1 force ALIGN, 0 force none, -1 whatever parity happens to be.
    // *_idx: byte index at whose GET cycle to inject a $4014 write / pulse rst / stall 5 clks (-1 = never).
    task automatic run_xfer(input logic [7:0] pg, input int want_align, input int ce_pct,
                            input int inject_idx, input int rst_idx, input int freeze_idx,
                            input string tag);
        int budget, inj_pos, rst_pos, frz_pos;
        bit frozen, injected, aborted;
        frozen = 0; injected = 0; aborted = 0; budget = 0;
        if (want_align >= 0)
            while ((m_ce_cnt % 2 == 1) != (want_align == 1))
                do_cycle(0, 1, 0, 16'h0000, 8'h00, tag);
        halted_obs = 0;
        puts_obs   = 0;
        do_cycle(0, 1, 1, 16'h4014, pg, tag);
        inj_pos = (inject_idx < 0) ? -1 : 1 + int'(m_align) + 2 * inject_idx;
        rst_pos = (rst_idx    < 0) ? -1 : 1 + int'(m_align) + 2 * rst_idx;
        frz_pos = (freeze_idx < 0) ? -1 : 1 + int'(m_align) + 2 * freeze_idx;
        while (m_busy && budget < 5000 && !aborted) begin
            budget++;
            if (m_pos == rst_pos) begin
                do_cycle(1, 1, 0, 16'h0000, 8'h00, {tag, "_rst"});
                aborted = 1;
            end else if (m_pos == frz_pos && !frozen) begin
                frozen = 1;
                // stalled with a would-be trigger on the bus: nothing may move
                repeat (5) do_cycle(0, 0, 1, 16'h4014, 8'h11, {tag, "_frz"});
            end else if (m_pos == inj_pos && !injected) begin
                injected = 1;
                do_cycle(0, 1, 1, 16'h4014, 8'h07, {tag, "_inj"});
            end else begin
                do_cycle(0, ($urandom_range(99) < ce_pct), 0, 16'($urandom), 8'($urandom), tag);
            end
        end
        if (budget >= 5000) begin
            failures++;
            $display("FAIL %s_timeout: transfer still busy after %0d clks, want done", tag, budget);
        end
        if (!aborted) begin
            check_int({tag, "_halted"}, halted_obs, 513 + int'(m_align));
            check_int({tag, "_puts"}, puts_obs, 256);
        end
    endtask

    typedef struct {
        bit          ce;
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        bit          e_rdy;
        bit          e_act;
        logic [15:0] e_addr;
        bit          e_rw;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst = 1; dif.cpu_ce = 0; dif.cpu_wr = 0; dif.cpu_addr = 0; dif.cpu_dout = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        // 1: reset state
        repeat (3) do_cycle(1, 1, 0, 16'h4014, 8'h00, "reset");
        check_int("reset_dout", int'(dif.bus_dout), 0);

        // trigger decode table (parity after reset: 4 ce cycles before HALT -> ALIGN)
        tbl[0] = '{1, 1, 16'h4015, 8'h55, 1, 0, 16'h0000, 1};
        tbl[1] = '{1, 0, 16'h4014, 8'h55, 1, 0, 16'h0000, 1};
        tbl[2] = '{0, 1, 16'h4014, 8'h55, 1, 0, 16'h0000, 1};
        tbl[3] = '{1, 1, 16'h0014, 8'h55, 1, 0, 16'h0000, 1};
        tbl[4] = '{1, 1, 16'h4014, 8'h02, 0, 1, 16'h4014, 1};
        tbl[5] = '{1, 0, 16'h0000, 8'h00, 0, 1, 16'h4014, 1};
        tbl[6] = '{1, 0, 16'h0000, 8'h00, 0, 1, 16'h0200, 1};
        tbl[7] = '{1, 0, 16'h0000, 8'h00, 0, 1, 16'h2004, 0};
        for (int i = 0; i < 8; i++) begin
            do_cycle(0, tbl[i].ce, tbl[i].wr, tbl[i].a, tbl[i].d, "table_model");
            checks++;
            if ({dif.rdy, dif.dma_active, dif.bus_addr, dif.bus_rw} !==
                {tbl[i].e_rdy, tbl[i].e_act, tbl[i].e_addr, tbl[i].e_rw}) begin
                failures++;
                $display("FAIL table[%0d]: got rdy=%b act=%b addr=%h rw=%b, want rdy=%b act=%b addr=%h rw=%b",
                         i, dif.rdy, dif.dma_active, dif.bus_addr, dif.bus_rw,
                         tbl[i].e_rdy, tbl[i].e_act, tbl[i].e_addr, tbl[i].e_rw);
            end
        end
        check_int("table_first_put", int'(dif.bus_dout), 8'hA5);
        repeat (2) do_cycle(1, 1, 0, 16'h0000, 8'h00, "reset2");

        // 2/3: full transfer from page 2, HALT on put then HALT on get
        run_xfer(8'h02, 0, 100, -1, -1, -1, "page2_noalign");
        run_xfer(8'h02, 1, 100, -1, -1, -1, "page2_align");

        // 4: trigger while busy is ignored
        run_xfer(8'h02, -1, 100, 10, -1, -1, "retrigger");

        // 5: reset mid-transfer, then restart from page 3
        run_xfer(8'h02, -1, 100, -1, 100, -1, "midrst");
        run_xfer(8'h03, -1, 100, -1, -1, -1, "after_rst");

        // 6: stall mid-GET on page $FF
        run_xfer(8'hFF, -1, 100, -1, -1, 37, "pageff_stall");

        // randomized pages, parity and cpu_ce gaps
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(5)) do_cycle(0, 1'($urandom), 0, 16'h0000, 8'h00, "gap");
            run_xfer(8'($urandom), -1, 60, -1, -1, -1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
